// File: rtl/alu_conv_mac.sv
// rtl/alu_conv_mac.sv - streaming multiply-accumulate dot-product unit
//
// Purpose: accepts LEN (A, B) operand pairs over a valid/ready handshake and
// presents their dot product Y on a valid/ready output. The result is held
// until the output handshake. Input is refused while a result is held.
// Optional feature: define ALU_CONV_SIGNED_EN for two's complement operands.
// Without it, operands are unsigned.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   clear      synchronous abort of partial sum and held result
//   in_valid   operand pair valid
//   in_ready   unit can take a pair (state-derived only)
//   A, B       operands, WIDTH bits
//   out_valid  Y holds a completed result
//   out_ready  downstream takes Y
//   Y          dot product, OUT_W bits
//   busy       partial sum in progress or result held

module alu_conv_mac #(
  parameter int WIDTH = 16,
  parameter int LEN   = 4,
  parameter int OUT_W = 2*WIDTH + $clog2(LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Y,
  output logic             busy
);

  localparam int CNT_W = $clog2(LEN);
  localparam int EXT_W = OUT_W - 2*WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] prod;
  logic [OUT_W-1:0]   prod_ext;
  logic [OUT_W-1:0]   sum;
  logic               beat;
  logic               last_beat;

`ifdef ALU_CONV_SIGNED_EN
  // The multiply is evaluated at 2*WIDTH in signed context.
  // Because of that, the product bits are exact. The top product bit then
  // carries the sign into the guard bits.
  assign prod     = $signed(A) * $signed(B);
  assign prod_ext = {{EXT_W{prod[2*WIDTH-1]}}, prod};
`else
  assign prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign prod_ext = {{EXT_W{1'b0}}, prod};
`endif

  assign sum       = acc_q + prod_ext;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (count_q == LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides both handshakes
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (beat)      state_d = last_beat ? HOLD : ACCUM;
        ACCUM:   if (last_beat) state_d = HOLD;
        HOLD:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  // Datapath next values. Clear leaves Y alone so the last result stays visible.
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    y_d     = y_q;
    if (clear) begin
      count_d = '0;
      acc_d   = '0;
    end else if (last_beat) begin
      y_d     = sum;
      acc_d   = '0;
      count_d = '0;
    end else if (beat) begin
      acc_d   = sum;
      count_d = count_q + 1'b1;
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    busy      = (count_q != '0) || (state_q == HOLD);
  end

  assign Y = y_q;

endmodule
